// File: rtl/ifu_prefetch_if.sv
// Decode-side, redirect and AXI-style read-port signals of the prefetch unit.
// The master modport is the fetch unit's view; slave is the environment's view.
interface ifu_prefetch_if #(
    parameter int XLEN = 64
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    logic            ar_valid;
    logic            ar_ready;
    logic [XLEN-1:0] ar_addr;
    logic [7:0]      ar_size;

    logic            r_valid;
    logic            r_ready;
    logic [XLEN-1:0] r_data;
    logic [1:0]      r_resp;

    modport master (
        input  redirect_valid, redirect_pc, inst_ready, ar_ready, r_valid, r_data, r_resp,
        output inst_valid, inst, inst_pc, inst_fault, ar_valid, ar_addr, ar_size, r_ready
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_ready, ar_ready, r_valid, r_data, r_resp,
        input  inst_valid, inst, inst_pc, inst_fault, ar_valid, ar_addr, ar_size, r_ready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: one outstanding read at a time feeding a DEPTH-entry queue,
// with redirect flush, stale-beat draining and halt-on-bus-error.
module ifu_prefetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ifu_prefetch_if.master    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [XLEN-1:0] r_ar_addr;
    logic            r_stale;
    logic            w_stale_next;
    logic            r_halted;
    logic            w_halted_next;

    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;

    logic [31:0]     r_mem_inst  [DEPTH];
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic            r_mem_fault [DEPTH];

    logic            w_redirect;
    logic            w_push;
    logic            w_pop;
    logic            w_err;
    logic            w_head_valid;
    logic [31:0]     w_lane;
    logic            w_unused;

    assign w_redirect   = bus.redirect_valid;
    assign w_err        = (bus.r_resp != 2'b00);
    assign w_head_valid = (r_count != '0);
    assign w_push       = (r_state == S_WAIT) && bus.r_valid && !w_redirect;
    assign w_pop        = w_head_valid && bus.inst_ready && !w_redirect;
    assign w_lane       = r_ar_addr[2] ? bus.r_data[63:32] : bus.r_data[31:0];
    assign w_unused     = ^bus.redirect_pc[1:0];

    always_comb begin
        w_count_next = r_count;
        if (w_redirect) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_stale_next    = r_stale;
        w_halted_next   = r_halted;
        case (r_state)
            S_IDLE: begin
                if (!w_redirect && !r_halted && (r_count < CW'(DEPTH))) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // The address already on the bus cannot be withdrawn; a redirect
                // only marks it stale so its beat gets drained.
                if (bus.ar_ready) begin
                    w_state_next = (w_redirect || r_stale) ? S_DRAIN : S_WAIT;
                    w_stale_next = 1'b0;
                end else if (w_redirect) begin
                    w_stale_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.r_valid) begin
                    if (w_redirect) begin
                        w_state_next = S_IDLE;
                    end else if (w_err) begin
                        w_halted_next = 1'b1;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_fetch_pc_next = r_fetch_pc + XLEN'(4);
                        w_state_next    = (w_count_next < CW'(DEPTH)) ? S_REQ : S_IDLE;
                    end
                end else if (w_redirect) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A beat arriving together with a redirect is still the stale one.
                if (bus.r_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_redirect) begin
            w_fetch_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
            w_halted_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_ar_addr  <= '0;
            r_stale    <= 1'b0;
            r_halted   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_stale    <= w_stale_next;
            r_halted   <= w_halted_next;
            r_count    <= w_count_next;
            if (w_state_next == S_REQ && r_state != S_REQ) begin
                r_ar_addr <= w_fetch_pc_next;
            end
            if (w_redirect) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr]  <= w_err ? 32'h0 : w_lane;
            r_mem_pc[r_wptr]    <= r_ar_addr;
            r_mem_fault[r_wptr] <= w_err;
        end
    end

    assign bus.inst_valid = w_head_valid;
    assign bus.inst       = w_head_valid ? r_mem_inst[r_rptr] : 32'h0;
    assign bus.inst_pc    = w_head_valid ? r_mem_pc[r_rptr] : '0;
    assign bus.inst_fault = w_head_valid ? r_mem_fault[r_rptr] : 1'b0;
    assign bus.ar_valid   = (r_state == S_REQ);
    assign bus.ar_addr    = r_ar_addr;
    assign bus.ar_size    = 8'b0000_1111;
    assign bus.r_ready    = (r_state == S_WAIT) || (r_state == S_DRAIN);
endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: a bus responder plus a reference model that
// predicts the delivered instruction stream as consecutive PCs from each restart point.
module tb_ifu_prefetch;
    localparam int          XLEN     = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.XLEN(XLEN)) bus ();

    ifu_prefetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus knobs
    int          ar_rdy_pct, inst_rdy_pct, redir_pct, dmin, dmax;
    bit          redir_req;
    logic [63:0] redir_target;
    logic [63:0] err_addr;
    bit          rand_err;

    // bus responder
    bit          pend;
    logic [63:0] pend_addr;
    int          pend_dly;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
        int          cyc;
    } pop_t;
    logic [63:0] ar_log[$];
    int          ar_cyc[$];
    pop_t        pop_log[$];

    // reference model
    logic [63:0] m_pc;
    bit          m_halted;
    bit          exp_empty;

    // protocol-stability history
    bit          p_ar_stall;
    logic [63:0] p_ar_addr;
    bit          p_inst_stall;
    logic [31:0] p_inst;
    logic [63:0] p_pc;
    logic        p_fault;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        logic [31:0] idx;
        w   = {a[63:2], 2'b00};
        idx = w[33:2];
        if (w == 64'h8000_0000) return 32'h0000_0413;
        if (w == 64'h8000_0004) return 32'h0010_0073;
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit is_fault(input logic [63:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return (a == err_addr) || (rand_err && (w[7:4] == 4'h0));
    endfunction

    function automatic bit pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    task automatic step();
        bit          do_redir;
        logic [63:0] tgt;
        logic [63:0] base;
        logic [31:0] exp_inst;
        bit          exp_fault;
        pop_t        pe;
        @(negedge clk);
        cyc++;
        if (exp_empty) check_eq("flush_empty", bus.inst_valid, 1'b0);
        exp_empty = 1'b0;
        if (p_ar_stall) begin
            check_eq("ar_hold_valid", bus.ar_valid, 1'b1);
            check_eq("ar_hold_addr", bus.ar_addr, p_ar_addr);
        end
        if (p_inst_stall) begin
            check_eq("head_hold_valid", bus.inst_valid, 1'b1);
            check_eq("head_hold_inst", bus.inst, p_inst);
            check_eq("head_hold_pc", bus.inst_pc, p_pc);
            check_eq("head_hold_fault", bus.inst_fault, p_fault);
        end
        if (m_halted) check_eq("halted_no_req", bus.ar_valid, 1'b0);
        if (bus.ar_valid) check_eq("ar_size", bus.ar_size, 8'h0F);

        bus.ar_ready   = pct(ar_rdy_pct);
        bus.inst_ready = pct(inst_rdy_pct);
        do_redir = redir_req || pct(redir_pct);
        tgt = redir_req ? redir_target : {32'h0, 32'h8000_0000 | ($urandom() & 32'h0000_FFFF)};
        redir_req = 1'b0;
        bus.redirect_valid = do_redir;
        bus.redirect_pc    = do_redir ? tgt : {$urandom(), $urandom()};

        if (pend && pend_dly == 0) begin
            base = {pend_addr[63:3], 3'b000};
            bus.r_valid = 1'b1;
            bus.r_data  = {mem_word(base + 64'd4), mem_word(base)};
            bus.r_resp  = is_fault(pend_addr) ? 2'b10 : 2'b00;
        end else begin
            bus.r_valid = 1'b0;
            bus.r_data  = {$urandom(), $urandom()};
            bus.r_resp  = 2'($urandom());
            if (pend) pend_dly--;
        end
        if (bus.r_valid && bus.r_ready) pend = 1'b0;
        if (bus.ar_valid && bus.ar_ready) begin
            pend      = 1'b1;
            pend_addr = bus.ar_addr;
            pend_dly  = $urandom_range(dmin, dmax);
            ar_log.push_back(bus.ar_addr);
            ar_cyc.push_back(cyc);
        end

        if (bus.inst_valid && bus.inst_ready && !do_redir) begin
            pe.pc = bus.inst_pc; pe.inst = bus.inst; pe.fault = bus.inst_fault; pe.cyc = cyc;
            pop_log.push_back(pe);
            $display("cycle %0d: delivered pc=%h inst=%h fault=%0d", cyc, pe.pc, pe.inst, pe.fault);
            if (m_halted) begin
                check_eq("delivery_after_fault", bus.inst_valid, 1'b0);
            end else begin
                exp_fault = is_fault(m_pc);
                exp_inst  = exp_fault ? 32'h0 : mem_word(m_pc);
                check_eq("pop_pc", bus.inst_pc, m_pc);
                check_eq("pop_inst", bus.inst, exp_inst);
                check_eq("pop_fault", bus.inst_fault, exp_fault);
                m_pc     = m_pc + 64'd4;
                m_halted = exp_fault;
            end
        end
        if (do_redir) begin
            m_pc      = {tgt[63:2], 2'b00};
            m_halted  = 1'b0;
            exp_empty = 1'b1;
        end

        p_ar_stall   = bus.ar_valid && !bus.ar_ready;
        p_ar_addr    = bus.ar_addr;
        p_inst_stall = bus.inst_valid && !bus.inst_ready && !do_redir;
        p_inst       = bus.inst;
        p_pc         = bus.inst_pc;
        p_fault      = bus.inst_fault;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;
        bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = 2'b00;
        ar_rdy_pct = 100; inst_rdy_pct = 100; redir_pct = 0; dmin = 0; dmax = 0;
        redir_req = 1'b0; err_addr = '1; rand_err = 1'b0;
        pend = 1'b0; pend_dly = 0;
        ar_log.delete(); ar_cyc.delete(); pop_log.delete();
        m_pc = RESET_PC; m_halted = 1'b0; exp_empty = 1'b0;
        p_ar_stall = 1'b0; p_inst_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_inst_valid", bus.inst_valid, 1'b0);
        check_eq("rst_inst_fault", bus.inst_fault, 1'b0);
        check_eq("rst_inst", bus.inst, 32'h0);
        check_eq("rst_inst_pc", bus.inst_pc, 64'h0);
        check_eq("rst_ar_valid", bus.ar_valid, 1'b0);
        check_eq("rst_ar_addr", bus.ar_addr, 64'h0);
        check_eq("rst_r_ready", bus.r_ready, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int np;
        int guard;

        // basic fetch, lane select, latency and throughput
        do_reset();
        steps(12);
        check_eq("t1_first_addr", ar_log[0], 64'h8000_0000);
        check_eq("t1_second_addr", ar_log[1], 64'h8000_0004);
        check_eq("t1_pop0_inst", pop_log[0].inst, 32'h0000_0413);
        check_eq("t1_pop0_pc", pop_log[0].pc, 64'h8000_0000);
        check_eq("t1_pop1_inst", pop_log[1].inst, 32'h0010_0073);
        check_eq("t1_latency", 64'(pop_log[0].cyc - ar_cyc[0]), 64'd2);
        check_eq("t1_throughput", 64'(pop_log[1].cyc - pop_log[0].cyc), 64'd2);

        // back-pressure fills the queue exactly
        do_reset();
        inst_rdy_pct = 0;
        steps(30);
        check_eq("t2_nfetch", 64'(ar_log.size()), 64'd4);
        check_eq("t2_last_addr", ar_log[3], 64'h8000_000C);
        check_eq("t2_full_no_req", bus.ar_valid, 1'b0);
        check_eq("t2_head_pc", bus.inst_pc, 64'h8000_0000);
        inst_rdy_pct = 100;
        step();
        inst_rdy_pct = 0;
        steps(20);
        check_eq("t2_nfetch_after_pop", 64'(ar_log.size()), 64'd5);
        check_eq("t2_refill_addr", ar_log[4], 64'h8000_0010);

        // redirect during WAIT_DATA, stale beat three cycles later
        do_reset();
        dmin = 3; dmax = 3;
        guard = 0;
        while (ar_log.size() < 3 && guard < 100) begin step(); guard++; end
        check_eq("t3_reach_third_fetch", 64'(ar_log.size()), 64'd3);
        check_eq("t3_third_addr", ar_log[2], 64'h8000_0008);
        redir_req = 1'b1; redir_target = 64'h8000_1000;
        n  = ar_log.size();
        np = pop_log.size();
        step();
        dmin = 0; dmax = 0;
        steps(20);
        check_eq("t3_next_addr", ar_log[n], 64'h8000_1000);
        check_eq("t3_first_pop_pc", pop_log[np].pc, 64'h8000_1000);

        // redirect while the address phase is stalled
        do_reset();
        guard = 0;
        while (ar_log.size() < 1 && guard < 100) begin step(); guard++; end
        ar_rdy_pct = 0;
        guard = 0;
        do begin step(); guard++; end while (!bus.ar_valid && guard < 100);
        check_eq("t4_req_pending", bus.ar_valid, 1'b1);
        redir_req = 1'b1; redir_target = 64'h8000_2000;
        step();
        steps(3);
        check_eq("t4_stale_valid", bus.ar_valid, 1'b1);
        check_eq("t4_stale_addr", bus.ar_addr, 64'h8000_0004);
        ar_rdy_pct = 100;
        n = ar_log.size();
        steps(20);
        check_eq("t4_stale_hs_addr", ar_log[n], 64'h8000_0004);
        check_eq("t4_target_addr", ar_log[n+1], 64'h8000_2000);

        // bus error halts fetch until redirected
        do_reset();
        err_addr = 64'h8000_0004;
        steps(30);
        check_eq("t5_npop", 64'(pop_log.size()), 64'd2);
        check_eq("t5_fault_flag", pop_log[1].fault, 1'b1);
        check_eq("t5_fault_inst", pop_log[1].inst, 32'h0);
        check_eq("t5_fault_pc", pop_log[1].pc, 64'h8000_0004);
        check_eq("t5_nfetch", 64'(ar_log.size()), 64'd2);
        redir_req = 1'b1; redir_target = 64'h8000_0100;
        n = ar_log.size();
        steps(10);
        check_eq("t5_resume_addr", ar_log[n], 64'h8000_0100);

        // misaligned redirect target, then asynchronous reset mid-transaction
        do_reset();
        redir_req = 1'b1; redir_target = 64'h8000_0106;
        steps(20);
        check_eq("t6_aligned_addr", ar_log[1], 64'h8000_0104);
        inst_rdy_pct = 0; dmin = 4; dmax = 4;
        guard = 0;
        do begin step(); guard++; end while (!(bus.r_ready && bus.inst_valid) && guard < 100);
        check_eq("t6_pre_r_ready", bus.r_ready, 1'b1);
        check_eq("t6_pre_inst_valid", bus.inst_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_ar_valid", bus.ar_valid, 1'b0);
        check_eq("t6_async_r_ready", bus.r_ready, 1'b0);
        check_eq("t6_async_inst_valid", bus.inst_valid, 1'b0);

        // randomized traffic against the reference model
        do_reset();
        rand_err = 1'b1;
        for (int blk = 0; blk < 30; blk++) begin
            ar_rdy_pct   = $urandom_range(30, 100);
            inst_rdy_pct = $urandom_range(20, 100);
            redir_pct    = $urandom_range(1, 6);
            dmax         = $urandom_range(0, 4);
            steps(100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
